// File: rtl/ds_slave_pkg.sv
// Shared types and default timing for the 1-wire bit-level responder.
package ds_slave_pkg;

  // Default slot timings in clk cycles at 25 MHz.
  localparam int unsigned DS_CNT_W        = 14;
  localparam int unsigned DS_CNT_SAMPLE   = 750;
  localparam int unsigned DS_CNT_RD_HOLD  = 750;
  localparam int unsigned DS_CNT_RST_MIN  = 10000;
  localparam int unsigned DS_CNT_PRES_DLY = 750;
  localparam int unsigned DS_CNT_PRES     = 3000;

  // Consecutive synced low samples needed before the glitch filter reports a low.
  localparam int unsigned DS_FILT_LEN = 3;

  typedef enum logic [2:0] {
    IDLE,
    RD_HOLD,
    SLOT,
    WAIT_HIGH,
    RST_LOW,
    PRES_DLY,
    PRES,
    PRES_REL
  } ds_state_e;

endpackage

// File: rtl/ds_in_sync.sv
// dq input conditioning: 2-flop synchronizer, optional low-glitch filter
// (DS_SLAVE_GLITCH_FILTER_EN), falling-edge detect on the conditioned level.
module ds_in_sync
  import ds_slave_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic dq_i,
  output logic dq_s_o,
  output logic fall_det_o
);

  logic sync1_q;
  logic sync2_q;
  logic lvl_q;
  logic dq_s;

`ifdef DS_SLAVE_GLITCH_FILTER_EN
  logic [DS_FILT_LEN-2:0] hist_q;

  // Level reads low only once the last DS_FILT_LEN synced samples are all low.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '1;
    end else begin
      hist_q <= (DS_FILT_LEN-1)'({hist_q, sync2_q});
    end
  end

  assign dq_s = sync2_q | (|hist_q);
`else
  assign dq_s = sync2_q;
`endif

  // Reset to the idle-high bus level so leaving reset never looks like a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      lvl_q   <= 1'b1;
    end else begin
      sync1_q <= dq_i;
      sync2_q <= sync1_q;
      lvl_q   <= dq_s;
    end
  end

  assign dq_s_o     = dq_s;
  assign fall_det_o = lvl_q & ~dq_s;

endmodule

// File: rtl/ds_slave_bit.sv
// 1-wire slave bit layer: reset/presence, write-slot sampling, read-slot drive.
// Optional input glitch filter selected by DS_SLAVE_GLITCH_FILTER_EN.
module ds_slave_bit
  import ds_slave_pkg::*;
#(
  parameter int unsigned CNT_W        = DS_CNT_W,
  parameter int unsigned CNT_SAMPLE   = DS_CNT_SAMPLE,
  parameter int unsigned CNT_RD_HOLD  = DS_CNT_RD_HOLD,
  parameter int unsigned CNT_RST_MIN  = DS_CNT_RST_MIN,
  parameter int unsigned CNT_PRES_DLY = DS_CNT_PRES_DLY,
  parameter int unsigned CNT_PRES     = DS_CNT_PRES
) (
  input  logic clk,
  input  logic rst,
  input  logic dq_in,
  output logic dq_out,
  output logic dq_out_en,
  input  logic tx_en,
  input  logic tx_bit,
  output logic rx_bit,
  output logic rx_vld,
  output logic tx_done,
  output logic rst_det,
  output logic busy
);

  localparam logic [CNT_W-1:0] SAMPLE_LAST   = CNT_W'(CNT_SAMPLE - 1);
  localparam logic [CNT_W-1:0] RD_HOLD_LAST  = CNT_W'(CNT_RD_HOLD - 1);
  localparam logic [CNT_W-1:0] RST_LAST      = CNT_W'(CNT_RST_MIN - 1);
  localparam logic [CNT_W-1:0] PRES_DLY_LAST = CNT_W'(CNT_PRES_DLY - 1);
  localparam logic [CNT_W-1:0] PRES_LAST     = CNT_W'(CNT_PRES - 1);

  ds_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             tx_en_q;
  logic             dq_en_q;
  logic             rx_bit_q;
  logic             rx_vld_q;
  logic             tx_done_q;
  logic             rst_det_q;
  logic             busy_q;
  logic             dq_s;
  logic             fall_det;

  ds_in_sync u_in_sync (
    .clk        (clk),
    .rst        (rst),
    .dq_i       (dq_in),
    .dq_s_o     (dq_s),
    .fall_det_o (fall_det)
  );

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

  // Slot FSM; cnt restarts on each state entry except SLOT -> WAIT_HIGH,
  // where it keeps measuring the low time from detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_en_q   <= 1'b0;
      dq_en_q   <= 1'b0;
      rx_bit_q  <= 1'b0;
      rx_vld_q  <= 1'b0;
      tx_done_q <= 1'b0;
      rst_det_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rx_vld_q  <= 1'b0;
      tx_done_q <= 1'b0;
      rst_det_q <= 1'b0;
      cnt_q     <= cnt_inc;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (fall_det) begin
            tx_en_q <= tx_en;
            busy_q  <= 1'b1;
            if (tx_en && !tx_bit) begin
              state_q <= RD_HOLD;
              dq_en_q <= 1'b1;
            end else begin
              state_q <= SLOT;
            end
          end
        end
        RD_HOLD: begin
          if (cnt_q == RD_HOLD_LAST) begin
            state_q   <= WAIT_HIGH;
            dq_en_q   <= 1'b0;
            tx_done_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        SLOT: begin
          // Only reachable when the reset threshold is set below the sample point.
          if (!dq_s && (cnt_q >= RST_LAST)) begin
            state_q <= RST_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == SAMPLE_LAST) begin
            state_q <= WAIT_HIGH;
            if (tx_en_q) begin
              tx_done_q <= 1'b1;
            end else begin
              rx_vld_q <= 1'b1;
              rx_bit_q <= dq_s;
            end
          end
        end
        WAIT_HIGH: begin
          if (dq_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q >= RST_LAST) begin
            state_q <= RST_LOW;
            cnt_q   <= '0;
          end
        end
        RST_LOW: begin
          if (dq_s) begin
            state_q <= PRES_DLY;
            cnt_q   <= '0;
          end
        end
        PRES_DLY: begin
          if (cnt_q == PRES_DLY_LAST) begin
            state_q <= PRES;
            dq_en_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        PRES: begin
          if (cnt_q == PRES_LAST) begin
            state_q <= PRES_REL;
            dq_en_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        PRES_REL: begin
          if (dq_s) begin
            state_q   <= IDLE;
            rst_det_q <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          dq_en_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dq_out    = 1'b0;
  assign dq_out_en = dq_en_q;
  assign rx_bit    = rx_bit_q;
  assign rx_vld    = rx_vld_q;
  assign tx_done   = tx_done_q;
  assign rst_det   = rst_det_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ds_slave_bit.sv
// Directed bench for ds_slave_bit: reset/presence, write 0/1, read 0/1,
// reset during presence, and 1-cycle glitch handling.
module tb_ds_slave_bit;

`ifdef DS_SLAVE_GLITCH_FILTER_EN
  localparam int DET_LAT = 5;
`else
  localparam int DET_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic m_low;
  logic dq_in;
  logic dq_out;
  logic dq_out_en;
  logic tx_en;
  logic tx_bit;
  logic rx_bit;
  logic rx_vld;
  logic tx_done;
  logic rst_det;
  logic busy;

  // Wired-AND bus: master or slave pulling low wins.
  assign dq_in = ~(m_low | dq_out_en);

  ds_slave_bit dut (
    .clk       (clk),
    .rst       (rst),
    .dq_in     (dq_in),
    .dq_out    (dq_out),
    .dq_out_en (dq_out_en),
    .tx_en     (tx_en),
    .tx_bit    (tx_bit),
    .rx_bit    (rx_bit),
    .rx_vld    (rx_vld),
    .tx_done   (tx_done),
    .rst_det   (rst_det),
    .busy      (busy)
  );

  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Event monitor, sampled on the falling edge.
  int   n_busy = 0, n_rx = 0, n_tx = 0, n_rst = 0, n_dqo = 0;
  int   busy_rise = 0, en_rise = 0, en_fall = 0, en_len = 0;
  int   rx_cyc = 0, tx_cyc = 0, rx_val = 0;
  logic busy_p = 1'b0, en_p = 1'b0;

  always @(negedge clk) begin
    if (busy && !busy_p) begin
      n_busy++;
      busy_rise = cyc;
    end
    if (dq_out_en && !en_p) en_rise = cyc;
    if (!dq_out_en && en_p) begin
      en_fall = cyc;
      en_len  = cyc - en_rise;
    end
    if (rx_vld) begin
      n_rx++;
      rx_cyc = cyc;
      rx_val = int'(rx_bit);
    end
    if (tx_done) begin
      n_tx++;
      tx_cyc = cyc;
    end
    if (rst_det) n_rst++;
    if (dq_out) n_dqo++;
    busy_p = busy;
    en_p   = dq_out_en;
  end

  int c_fall, c_rel;
  int s_busy, s_rx, s_tx, s_rst, s_en;

  task automatic pulse_low(input int n);
    @(posedge clk);
    #1 m_low = 1'b1;
    c_fall = cyc;
    repeat (n) @(posedge clk);
    #1 m_low = 1'b0;
    c_rel = cyc;
  endtask

  task automatic wait_idle();
    int k = 0;
    repeat (10) @(posedge clk);
    while (busy && k < 20000) begin
      @(posedge clk);
      k++;
    end
    check("idle_timeout", int'(k >= 20000), 0);
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_busy = n_busy;
    s_rx   = n_rx;
    s_tx   = n_tx;
    s_rst  = n_rst;
    s_en   = en_rise;
  endtask

  initial begin
    rst    = 1'b1;
    m_low  = 1'b0;
    tx_en  = 1'b0;
    tx_bit = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_dq_out_en", int'(dq_out_en), 0);
    check("rst_rx_bit", int'(rx_bit), 0);
    check("rst_rx_vld", int'(rx_vld), 0);
    check("rst_tx_done", int'(tx_done), 0);
    check("rst_rst_det", int'(rst_det), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);

    // Bus reset: 500 us low, then presence.
    snap();
    pulse_low(12500);
    wait_idle();
    check("pres_delay", en_rise - c_rel, 753);
    check("pres_width", en_len, 3000);
    check("pres_rst_det", n_rst - s_rst, 1);
    check("pres_busy_end", int'(busy), 0);

    // Write 1: 2 us low.
    snap();
    pulse_low(50);
    wait_idle();
    check("w1_det_lat", busy_rise - c_fall, DET_LAT);
    check("w1_rx_cnt", n_rx - s_rx, 1);
    check("w1_rx_bit", rx_val, 1);
    check("w1_rx_time", rx_cyc - busy_rise, 750);
    check("w1_no_rst", n_rst - s_rst, 0);

    // Write 0: 60 us low.
    snap();
    pulse_low(1500);
    wait_idle();
    check("w0_rx_cnt", n_rx - s_rx, 1);
    check("w0_rx_bit", rx_val, 0);
    check("w0_rx_time", rx_cyc - busy_rise, 750);
    check("w0_rx_hold", int'(rx_bit), 0);
    check("w0_no_rst", n_rst - s_rst, 0);

    // Read 0; inputs changed after detection must be ignored.
    snap();
    tx_en  = 1'b1;
    tx_bit = 1'b0;
    pulse_low(25);
    tx_en  = 1'b0;
    tx_bit = 1'b1;
    wait_idle();
    check("r0_en_start", en_rise - busy_rise, 0);
    check("r0_en_width", en_len, 750);
    check("r0_tx_cnt", n_tx - s_tx, 1);
    check("r0_tx_at_fall", tx_cyc - en_fall, 0);
    check("r0_no_rx", n_rx - s_rx, 0);
    check("r0_no_rst", n_rst - s_rst, 0);

    // Read 1: no drive, tx_done at the sample point.
    snap();
    tx_en  = 1'b1;
    tx_bit = 1'b1;
    pulse_low(25);
    tx_en  = 1'b0;
    tx_bit = 1'b0;
    wait_idle();
    check("r1_no_drive", en_rise - s_en, 0);
    check("r1_tx_cnt", n_tx - s_tx, 1);
    check("r1_tx_time", tx_cyc - busy_rise, 750);
    check("r1_no_rx", n_rx - s_rx, 0);

    // One-cycle glitch.
    snap();
    pulse_low(1);
    wait_idle();
`ifdef DS_SLAVE_GLITCH_FILTER_EN
    check("gl_no_busy", n_busy - s_busy, 0);
    check("gl_no_rx", n_rx - s_rx, 0);
`else
    check("gl_rx_cnt", n_rx - s_rx, 1);
    check("gl_rx_bit", rx_val, 1);
`endif

    // Synchronous reset in the middle of the presence pulse.
    snap();
    pulse_low(12500);
    begin
      int k = 0;
      while (!dq_out_en && k < 5000) begin
        @(posedge clk);
        k++;
      end
      check("mid_pres_timeout", int'(k >= 5000), 0);
    end
    repeat (1000) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_en", int'(dq_out_en), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rx_vld", int'(rx_vld), 0);
    check("mid_rst_tx_done", int'(tx_done), 0);
    check("mid_rst_rst_det", int'(rst_det), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4000) @(posedge clk);
    #1;
    check("mid_rst_no_det", n_rst - s_rst, 0);
    check("mid_rst_idle_en", int'(dq_out_en), 0);
    check("dq_out_zero", n_dqo, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
